a2_slot_arbiter: RTL and testbench

Sequences Apple II slot-space accesses for up to `NUM_CARDS` soft peripheral cards hosted in the FPGA. Sits directly behind the bus interface on `clk_logic_i`. Decodes each latched bus cycle into per-card I/O, device and expansion-ROM selects, and tracks $C800 expansion-ROM ownership. Arbitrates which card's read data drives the bus during Phi0, and flags multi-driver conflicts.

---
 rtl/a2_slot_arb_pkg.sv | 25 ++
 rtl/a2_slot_decoder.sv | 26 ++
 rtl/a2_slot_arbiter.sv | 205 ++++++++++++++++++++
 tb/tb_a2_slot_arbiter.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/a2_slot_arb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | a2_slot_arb_pkg : shared types and address constants for the       |
// |                   Apple II slot-space arbiter.                     |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package a2_slot_arb_pkg;

    localparam int SLOT_W = 3;

    localparam logic [15:0] IO_BASE     = 16'hC080;
    localparam logic [15:0] C8_START    = 16'hC800;
    localparam logic [15:0] C8_END      = 16'hCFFE;
    localparam logic [15:0] C8_CLEAR    = 16'hCFFF;
    localparam logic [4:0]  DEV_PAGE_HI = 5'b11000;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SELECT    = 2'd1,
        ST_WAIT_DATA = 2'd2,
        ST_DRIVE     = 2'd3
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/a2_slot_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | a2_slot_decoder : per-card combinational slot-space address decode |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module a2_slot_decoder
    import a2_slot_arb_pkg::*;
(
    input  logic [15:0]       addr_i,
    input  logic [SLOT_W-1:0] slot_i,
    input  logic              owner_i,
    output logic              io_hit_o,
    output logic              dev_hit_o,
    output logic              rom_hit_o
);

    logic enabled;

    // Slot 0 marks an unplugged card; it never decodes anything.
    assign enabled   = (slot_i != '0);
    assign io_hit_o  = enabled && (addr_i[15:7] == IO_BASE[15:7]) && (addr_i[6:4] == slot_i);
    assign dev_hit_o = enabled && (addr_i[15:8] == {DEV_PAGE_HI, slot_i});
    assign rom_hit_o = enabled && owner_i && (addr_i >= C8_START) && (addr_i <= C8_END);

endmodule
`default_nettype wire

// File: rtl/a2_slot_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | a2_slot_arbiter : slot-space select, $C800 ownership and read-data |
// |                   arbitration for FPGA-hosted peripheral cards.    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module a2_slot_arbiter
    import a2_slot_arb_pkg::*;
#(
    parameter int NUM_CARDS   = 4,
    parameter int RESP_WINDOW = 4
) (
    input  logic                        clk_logic_i,
    input  logic                        system_reset_i,
    input  logic [15:0]                 addr_i,
    input  logic                        rw_n_i,
    input  logic [7:0]                  data_i,
    input  logic                        phi0_posedge_i,
    input  logic                        phi1_posedge_i,
    input  logic                        data_in_strobe_i,
    input  logic                        control_reset_n_i,
    input  logic [SLOT_W*NUM_CARDS-1:0] card_slot_i,
    input  logic [8*NUM_CARDS-1:0]      card_rd_data_i,
    input  logic [NUM_CARDS-1:0]        card_rd_valid_i,
    output logic [NUM_CARDS-1:0]        card_io_sel_o,
    output logic [NUM_CARDS-1:0]        card_dev_sel_o,
    output logic [NUM_CARDS-1:0]        card_rom_sel_o,
    output logic [NUM_CARDS-1:0]        card_wr_strobe_o,
    output logic [7:0]                  data_o,
    output logic                        data_oe_o,
    output logic [NUM_CARDS-1:0]        c8_owner_o,
    output logic                        conflict_o
);

    localparam logic [3:0] WINDOW = 4'(RESP_WINDOW);

    arb_state_t           state_q, state_d;
    logic [NUM_CARDS-1:0] io_hit, dev_hit, rom_hit;
    logic [NUM_CARDS-1:0] io_hit_q, io_hit_d;
    logic [NUM_CARDS-1:0] dev_hit_q, dev_hit_d;
    logic [NUM_CARDS-1:0] rom_hit_q, rom_hit_d;
    logic [NUM_CARDS-1:0] owner_q, owner_d;
    logic [NUM_CARDS-1:0] sel_hit_q;
    logic [NUM_CARDS-1:0] dev_pick;
    logic                 rw_q, rw_d;
    logic                 active_q, active_d;
    logic                 cfff_q, cfff_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [7:0]           data_q, data_d;
    logic                 conflict_q, conflict_d;
    logic [7:0]           rd_data;
    logic                 any_valid, multi_valid, dev_seen;
    logic                 unused_data;

    // Write data reaches the cards directly; the port exists for bus completeness.
    assign unused_data = ^data_i;

    for (genvar i = 0; i < NUM_CARDS; i++) begin : g_dec
        a2_slot_decoder u_dec (
            .addr_i    (addr_i),
            .slot_i    (card_slot_i[i*SLOT_W +: SLOT_W]),
            .owner_i   (owner_q[i]),
            .io_hit_o  (io_hit[i]),
            .dev_hit_o (dev_hit[i]),
            .rom_hit_o (rom_hit[i])
        );
    end

    // Lowest-index priority for both the read driver and the new $C800 owner.
    always_comb begin
        rd_data     = 8'h00;
        any_valid   = 1'b0;
        multi_valid = 1'b0;
        dev_pick    = '0;
        dev_seen    = 1'b0;
        for (int i = 0; i < NUM_CARDS; i++) begin
            if (card_rd_valid_i[i]) begin
                if (!any_valid) begin
                    rd_data = card_rd_data_i[i*8 +: 8];
                end else begin
                    multi_valid = 1'b1;
                end
                any_valid = 1'b1;
            end
            if (dev_hit_q[i] && !dev_seen) begin
                dev_pick[i] = 1'b1;
                dev_seen    = 1'b1;
            end
        end
    end

    assign sel_hit_q = io_hit_q | dev_hit_q | rom_hit_q;

    always_comb begin
        state_d    = state_q;
        io_hit_d   = io_hit_q;
        dev_hit_d  = dev_hit_q;
        rom_hit_d  = rom_hit_q;
        rw_d       = rw_q;
        active_d   = active_q;
        cfff_d     = cfff_q;
        cnt_d      = cnt_q;
        data_d     = data_q;
        conflict_d = 1'b0;
        owner_d    = owner_q;

        if (phi0_posedge_i) begin
            // A Phi0 edge always starts a fresh decode, even if Phi1 was missed.
            io_hit_d  = io_hit;
            dev_hit_d = dev_hit;
            rom_hit_d = rom_hit;
            rw_d      = rw_n_i;
            cfff_d    = (addr_i == C8_CLEAR);
            active_d  = 1'b1;
            cnt_d     = 4'd0;
            state_d   = ST_SELECT;
        end else begin
            if (phi1_posedge_i) begin
                active_d = 1'b0;
            end
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                ST_SELECT: begin
                    if (rw_q && (sel_hit_q != '0)) begin
                        cnt_d   = 4'd1;
                        state_d = ST_WAIT_DATA;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_WAIT_DATA: begin
                    if (any_valid) begin
                        data_d     = rd_data;
                        conflict_d = multi_valid;
                        state_d    = ST_DRIVE;
                    end else if (cnt_q >= WINDOW) begin
                        state_d = ST_IDLE;
                    end else if (cnt_q != 4'hF) begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                ST_DRIVE: begin
                    if (phi1_posedge_i) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        if (data_in_strobe_i && active_q) begin
            if (cfff_q) begin
                owner_d = '0;
            end else if (dev_seen) begin
                owner_d = dev_pick;
            end
        end
        if (!control_reset_n_i) begin
            owner_d = '0;
        end
    end

    always_ff @(posedge clk_logic_i) begin
        if (system_reset_i) begin
            state_q    <= ST_IDLE;
            io_hit_q   <= '0;
            dev_hit_q  <= '0;
            rom_hit_q  <= '0;
            rw_q       <= 1'b1;
            active_q   <= 1'b0;
            cfff_q     <= 1'b0;
            cnt_q      <= 4'd0;
            data_q     <= 8'h00;
            conflict_q <= 1'b0;
            owner_q    <= '0;
        end else begin
            state_q    <= state_d;
            io_hit_q   <= io_hit_d;
            dev_hit_q  <= dev_hit_d;
            rom_hit_q  <= rom_hit_d;
            rw_q       <= rw_d;
            active_q   <= active_d;
            cfff_q     <= cfff_d;
            cnt_q      <= cnt_d;
            data_q     <= data_d;
            conflict_q <= conflict_d;
            owner_q    <= owner_d;
        end
    end

    assign card_io_sel_o    = (state_q == ST_SELECT) ? io_hit_q  : '0;
    assign card_dev_sel_o   = (state_q == ST_SELECT) ? dev_hit_q : '0;
    assign card_rom_sel_o   = (state_q == ST_SELECT) ? rom_hit_q : '0;
    assign card_wr_strobe_o = (data_in_strobe_i && active_q && !rw_q) ? sel_hit_q : '0;
    assign data_o           = data_q;
    assign data_oe_o        = (state_q == ST_DRIVE);
    assign c8_owner_o       = owner_q;
    assign conflict_o       = conflict_q;

endmodule
`default_nettype wire

// File: tb/tb_a2_slot_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_a2_slot_arbiter : scoreboard bench for a2_slot_arbiter          |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_a2_slot_arbiter;

    localparam int NC = 4;

    logic          clk_logic_i = 1'b0;
    logic          system_reset_i;
    logic [15:0]   addr_i;
    logic          rw_n_i;
    logic [7:0]    data_i;
    logic          phi0_posedge_i;
    logic          phi1_posedge_i;
    logic          data_in_strobe_i;
    logic          control_reset_n_i;
    logic [3*NC-1:0] card_slot_i;
    logic [8*NC-1:0] card_rd_data_i;
    logic [NC-1:0] card_rd_valid_i;
    logic [NC-1:0] card_io_sel_o;
    logic [NC-1:0] card_dev_sel_o;
    logic [NC-1:0] card_rom_sel_o;
    logic [NC-1:0] card_wr_strobe_o;
    logic [7:0]    data_o;
    logic          data_oe_o;
    logic [NC-1:0] c8_owner_o;
    logic          conflict_o;

    a2_slot_arbiter #(.NUM_CARDS(NC), .RESP_WINDOW(4)) dut (
        .clk_logic_i       (clk_logic_i),
        .system_reset_i    (system_reset_i),
        .addr_i            (addr_i),
        .rw_n_i            (rw_n_i),
        .data_i            (data_i),
        .phi0_posedge_i    (phi0_posedge_i),
        .phi1_posedge_i    (phi1_posedge_i),
        .data_in_strobe_i  (data_in_strobe_i),
        .control_reset_n_i (control_reset_n_i),
        .card_slot_i       (card_slot_i),
        .card_rd_data_i    (card_rd_data_i),
        .card_rd_valid_i   (card_rd_valid_i),
        .card_io_sel_o     (card_io_sel_o),
        .card_dev_sel_o    (card_dev_sel_o),
        .card_rom_sel_o    (card_rom_sel_o),
        .card_wr_strobe_o  (card_wr_strobe_o),
        .data_o            (data_o),
        .data_oe_o         (data_oe_o),
        .c8_owner_o        (c8_owner_o),
        .conflict_o        (conflict_o)
    );

    always #5 clk_logic_i = ~clk_logic_i;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_q[$];
    int          cyc = 0;
    int          sel_cyc = 0;
    int          phi1_cyc = 0;
    logic        oe_prev = 1'b0;
    logic        rst_prev = 1'b1;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Event words: {kind[3:0], payload}
    function automatic logic [31:0] ev_sel(input logic [11:0] s);
        return {4'd1, 16'd0, s};
    endfunction
    function automatic logic [31:0] ev_wr(input logic st, input logic [3:0] w);
        return {4'd2, 23'd0, st, w};
    endfunction
    function automatic logic [31:0] ev_drv(input logic [7:0] lat, input logic c, input logic [7:0] d);
        return {4'd3, 11'd0, lat, c, d};
    endfunction
    function automatic logic [31:0] ev_fall(input logic [7:0] lat);
        return {4'd5, 20'd0, lat};
    endfunction

    task automatic observe(input logic [31:0] ev);
        string tag;
        case (ev[31:28])
            4'd1:    tag = "select";
            4'd2:    tag = "wr_strobe";
            4'd3:    tag = "drive_start";
            4'd4:    tag = "stray_conflict";
            default: tag = "drive_end";
        endcase
        if (exp_q.size() == 0) check_value({"unexpected_", tag}, ev, 32'h0);
        else                   check_value(tag, ev, exp_q.pop_front());
    endtask

    always @(negedge clk_logic_i) begin
        cyc++;
        if (!rst_prev) begin
            if ((card_io_sel_o | card_dev_sel_o | card_rom_sel_o) != '0) begin
                observe(ev_sel({card_io_sel_o, card_dev_sel_o, card_rom_sel_o}));
                sel_cyc = cyc;
            end
            if (card_wr_strobe_o != '0)
                observe(ev_wr(data_in_strobe_i, card_wr_strobe_o));
            if (data_oe_o && !oe_prev)
                observe(ev_drv(8'(cyc - sel_cyc), conflict_o, data_o));
            else if (conflict_o)
                observe({4'd4, 28'd1});
            if (!data_oe_o && oe_prev)
                observe(ev_fall(8'(cyc - phi1_cyc)));
            if (phi1_posedge_i) phi1_cyc = cyc;
        end
        oe_prev  = data_oe_o;
        rst_prev = system_reset_i;
    end

    task automatic step();
        @(posedge clk_logic_i);
        #1;
    endtask

    // One bus cycle: Phi1 boundary, Phi0 pulse, optional card response, data strobe.
    task automatic bus_cycle(input logic [15:0] addr, input logic rw, input logic [7:0] wdata,
                             input logic [3:0] vmask, input int vdly, input logic [31:0] rdata,
                             input logic [11:0] exp_sel, input int exp_lat, input logic exp_conf,
                             input logic [7:0] exp_data, input logic [3:0] exp_owner);
        if (exp_sel != 12'd0) exp_q.push_back(ev_sel(exp_sel));
        if (!rw && exp_sel != 12'd0)
            exp_q.push_back(ev_wr(1'b1, exp_sel[11:8] | exp_sel[7:4] | exp_sel[3:0]));
        if (exp_lat != 0) begin
            exp_q.push_back(ev_drv(8'(exp_lat), exp_conf, exp_data));
            exp_q.push_back(ev_fall(8'd1));
        end
        step(); addr_i = addr; rw_n_i = rw; data_i = wdata; card_rd_data_i = rdata; phi1_posedge_i = 1'b1;
        step(); phi1_posedge_i = 1'b0;
        step(); phi0_posedge_i = 1'b1;
        step(); phi0_posedge_i = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            step();
            if (k == vdly) card_rd_valid_i = vmask;
            data_in_strobe_i = (k == 8);
        end
        check_value($sformatf("owner_after_%04h", addr), {28'd0, c8_owner_o}, {28'd0, exp_owner});
        card_rd_valid_i = '0;
    endtask

    initial begin
        system_reset_i    = 1'b1;
        control_reset_n_i = 1'b1;
        addr_i            = 16'h0000;
        rw_n_i            = 1'b1;
        data_i            = 8'h00;
        phi0_posedge_i    = 1'b0;
        phi1_posedge_i    = 1'b0;
        data_in_strobe_i  = 1'b0;
        card_slot_i       = {3'd0, 3'd5, 3'd2, 3'd3};
        card_rd_data_i    = '0;
        card_rd_valid_i   = '0;
        repeat (3) step();
        check_value("rst_io_sel",  {28'd0, card_io_sel_o},    32'd0);
        check_value("rst_dev_sel", {28'd0, card_dev_sel_o},   32'd0);
        check_value("rst_rom_sel", {28'd0, card_rom_sel_o},   32'd0);
        check_value("rst_wr",      {28'd0, card_wr_strobe_o}, 32'd0);
        check_value("rst_data",    {24'd0, data_o},           32'd0);
        check_value("rst_oe",      {31'd0, data_oe_o},        32'd0);
        check_value("rst_owner",   {28'd0, c8_owner_o},       32'd0);
        check_value("rst_conflict",{31'd0, conflict_o},       32'd0);
        system_reset_i = 1'b0;
        step();

        //        addr      rw    wdata  vmask    dly rdata          sel{io,dev,rom}          lat conf data   owner
        bus_cycle(16'hC0B5, 1'b1, 8'h00, 4'b0001, 2, 32'h0000_00A5, {4'b0001,4'b0000,4'b0000}, 3, 1'b0, 8'hA5, 4'b0000);
        bus_cycle(16'hC305, 1'b1, 8'h00, 4'b0001, 1, 32'h0000_005A, {4'b0000,4'b0001,4'b0000}, 2, 1'b0, 8'h5A, 4'b0001);
        bus_cycle(16'hC812, 1'b1, 8'h00, 4'b0001, 4, 32'h0000_0077, {4'b0000,4'b0000,4'b0001}, 5, 1'b0, 8'h77, 4'b0001);
        bus_cycle(16'hC0A0, 1'b0, 8'h3C, 4'b0000, 0, 32'h0000_0000, {4'b0010,4'b0000,4'b0000}, 0, 1'b0, 8'h00, 4'b0001);
        bus_cycle(16'hC200, 1'b0, 8'hC3, 4'b0000, 0, 32'h0000_0000, {4'b0000,4'b0010,4'b0000}, 0, 1'b0, 8'h00, 4'b0010);
        bus_cycle(16'hC812, 1'b1, 8'h00, 4'b0010, 1, 32'h0000_6600, {4'b0000,4'b0000,4'b0010}, 2, 1'b0, 8'h66, 4'b0010);
        bus_cycle(16'hCFFF, 1'b1, 8'h00, 4'b0010, 1, 32'h0000_6600, 12'd0,                     0, 1'b0, 8'h00, 4'b0000);
        bus_cycle(16'hC800, 1'b1, 8'h00, 4'b0010, 1, 32'h0000_6600, 12'd0,                     0, 1'b0, 8'h00, 4'b0000);
        card_slot_i = {3'd0, 3'd5, 3'd2, 3'd5};
        bus_cycle(16'hC0D0, 1'b1, 8'h00, 4'b0101, 1, 32'h0022_0011, {4'b0101,4'b0000,4'b0000}, 2, 1'b1, 8'h11, 4'b0000);
        bus_cycle(16'hC0D0, 1'b1, 8'h00, 4'b0000, 0, 32'h0022_0011, {4'b0101,4'b0000,4'b0000}, 0, 1'b0, 8'h00, 4'b0000);
        bus_cycle(16'hC0D0, 1'b1, 8'h00, 4'b0100, 5, 32'h0022_0011, {4'b0101,4'b0000,4'b0000}, 0, 1'b0, 8'h00, 4'b0000);
        bus_cycle(16'hC0D0, 1'b1, 8'h00, 4'b0100, 4, 32'h0022_0011, {4'b0101,4'b0000,4'b0000}, 5, 1'b0, 8'h22, 4'b0000);
        bus_cycle(16'hC500, 1'b1, 8'h00, 4'b0000, 0, 32'h0000_0000, {4'b0000,4'b0101,4'b0000}, 0, 1'b0, 8'h00, 4'b0001);

        // System reset while driving a $C900 read.
        exp_q.push_back(ev_sel({4'b0000, 4'b0000, 4'b0001}));
        exp_q.push_back(ev_drv(8'd2, 1'b0, 8'h99));
        step(); addr_i = 16'hC900; rw_n_i = 1'b1; card_rd_data_i = 32'h0000_0099; phi1_posedge_i = 1'b1;
        step(); phi1_posedge_i = 1'b0;
        step(); phi0_posedge_i = 1'b1;
        step(); phi0_posedge_i = 1'b0;
        step(); card_rd_valid_i = 4'b0001;
        step();
        step();
        check_value("pre_rst_oe",    {31'd0, data_oe_o},  32'd1);
        check_value("pre_rst_owner", {28'd0, c8_owner_o}, 32'd1);
        system_reset_i = 1'b1;
        step();
        check_value("midrst_oe",       {31'd0, data_oe_o},  32'd0);
        check_value("midrst_owner",    {28'd0, c8_owner_o}, 32'd0);
        check_value("midrst_data",     {24'd0, data_o},     32'd0);
        check_value("midrst_conflict", {31'd0, conflict_o}, 32'd0);
        system_reset_i  = 1'b0;
        card_rd_valid_i = '0;

        // Apple /RESET clears ownership.
        bus_cycle(16'hC500, 1'b1, 8'h00, 4'b0000, 0, 32'h0000_0000, {4'b0000,4'b0101,4'b0000}, 0, 1'b0, 8'h00, 4'b0001);
        control_reset_n_i = 1'b0;
        step();
        control_reset_n_i = 1'b1;
        check_value("ctrl_reset_owner", {28'd0, c8_owner_o}, 32'd0);

        bus_cycle(16'h0000, 1'b1, 8'h00, 4'b0000, 0, 32'h0000_0000, 12'd0, 0, 1'b0, 8'h00, 4'b0000);
        repeat (3) step();
        check_value("queue_empty", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
